// File: rtl/corereset_pf_if.sv
// Reset-request and fabric-reset signal bundle for corereset_pf.
// master = clock/init subsystem side, slave = the reset generator.
interface corereset_pf_if;
    logic EXT_RST_N;
    logic PLL_LOCK;
    logic SS_BUSY;
    logic INIT_DONE;
    logic FF_US_RESTORE;
    logic FABRIC_RESET_N;

    modport master (
        output EXT_RST_N,
        output PLL_LOCK,
        output SS_BUSY,
        output INIT_DONE,
        output FF_US_RESTORE,
        input  FABRIC_RESET_N
    );

    modport slave (
        input  EXT_RST_N,
        input  PLL_LOCK,
        input  SS_BUSY,
        input  INIT_DONE,
        input  FF_US_RESTORE,
        output FABRIC_RESET_N
    );
endinterface

// File: rtl/corereset_pf.sv
// Fabric reset generator: async assert, CLK-synchronous release after
// SYNC_STAGES + DELAY_CYCLES clean edges.
module corereset_pf #(
    parameter int SYNC_STAGES  = 3,
    parameter int DELAY_CYCLES = 0
) (
    input logic           CLK,
    corereset_pf_if.slave rst_if
);
    localparam int SW = SYNC_STAGES - 1;
    localparam int CW = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY_CYCLES);

    logic rst_a;
    logic hold;

    assign rst_a = ~rst_if.EXT_RST_N | ~rst_if.PLL_LOCK | ~rst_if.INIT_DONE;
    assign hold  = rst_if.SS_BUSY | rst_if.FF_US_RESTORE;

    logic [SW-1:0] sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rel_q, rel_d;
    logic          sync_done;
    logic          cnt_done;

    assign sync_done = sync_q[SW-1];
    assign cnt_done  = (cnt_q == CNT_MAX);

    // The release flop itself is the final synchronizer stage, so the
    // chain holds SYNC_STAGES-1 flops and the latency stays exact.
    always_comb begin
        sync_d = sync_q;
        cnt_d  = cnt_q;
        rel_d  = rel_q;
        if (hold) begin
            sync_d = '0;
            cnt_d  = '0;
        end else begin
            sync_d = (sync_q << 1) | SW'(1);
            if (sync_done && !cnt_done)
                cnt_d = cnt_q + CW'(1);
            if (sync_done && cnt_done)
                rel_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst_a) begin
        if (rst_a) begin
            sync_q <= '0;
            cnt_q  <= '0;
            rel_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            rel_q  <= rel_d;
        end
    end

    assign rst_if.FABRIC_RESET_N = rel_q;
endmodule

// File: tb/tb_corereset_pf.sv
// Bench for corereset_pf: default and DELAY_CYCLES=5 instances driven in
// parallel, checked against a consecutive-clean-edge reference model.
module tb_corereset_pf;
    logic clk = 1'b0;
    always #50 clk = ~clk;

    bit ext = 1'b1, pll = 1'b1, ss = 1'b1, init = 1'b1, ff = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    corereset_pf_if a_if ();
    corereset_pf_if b_if ();

    assign a_if.EXT_RST_N     = ext;
    assign a_if.PLL_LOCK      = pll;
    assign a_if.SS_BUSY       = ss;
    assign a_if.INIT_DONE     = init;
    assign a_if.FF_US_RESTORE = ff;
    assign b_if.EXT_RST_N     = ext;
    assign b_if.PLL_LOCK      = pll;
    assign b_if.SS_BUSY       = ss;
    assign b_if.INIT_DONE     = init;
    assign b_if.FF_US_RESTORE = ff;

    corereset_pf u_a (
        .CLK    (clk),
        .rst_if (a_if.slave)
    );

    corereset_pf #(
        .SYNC_STAGES  (3),
        .DELAY_CYCLES (5)
    ) u_b (
        .CLK    (clk),
        .rst_if (b_if.slave)
    );

    // Reference: released once LAT consecutive edges saw no reset and
    // no hold; any reset request drops it immediately.
    wire rst_m = ~ext | ~pll | ~init;
    int  lat [2] = '{3, 8};
    int  mcnt[2] = '{0, 0};
    bit  mrel[2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst_m) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_m) begin
                mcnt[i] = 0;
                mrel[i] = 1'b0;
            end else if (!mrel[i]) begin
                if (ss || ff) begin
                    mcnt[i] = 0;
                end else begin
                    mcnt[i] = mcnt[i] + 1;
                    if (mcnt[i] >= lat[i])
                        mrel[i] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mdl_a", a_if.FABRIC_RESET_N, mrel[0] && !rst_m);
            chk("mdl_b", b_if.FABRIC_RESET_N, mrel[1] && !rst_m);
        end
    end

    task automatic release_chk(input string tag);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_a_e%0d", tag, k), a_if.FABRIC_RESET_N, k >= 3);
            chk($sformatf("%s_b_e%0d", tag, k), b_if.FABRIC_RESET_N, k >= 8);
        end
    endtask

    task automatic busy_seq(input int which);
        @(negedge clk);
        #10;
        pll = 1'b1; init = 1'b1; ss = 1'b1; ff = 1'b1;
        ext  = (which != 0);
        pll  = (which != 1);
        init = (which != 2);
        #100 ff = 1'b0;
        #100 ss = 1'b0;
        #100;
        chk($sformatf("t1_src%0d_a", which), a_if.FABRIC_RESET_N, 1'b0);
        chk($sformatf("t1_src%0d_b", which), b_if.FABRIC_RESET_N, 1'b0);
    endtask

    initial begin
        #1 ext = 1'b0;
        #19;
        chk("por_a", a_if.FABRIC_RESET_N, 1'b0);
        chk("por_b", b_if.FABRIC_RESET_N, 1'b0);
        mon_en = 1'b1;

        for (int j = 0; j < 3; j++)
            busy_seq(j);

        @(negedge clk);
        #10;
        ext = 1'b1; pll = 1'b1; init = 1'b1; ss = 1'b0; ff = 1'b0;
        release_chk("t3");

        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            #10 ext = 1'b0;
            #10 ext = 1'b1;
            if (j == 0) ss = 1'b1;
            else        ff = 1'b1;
            repeat (20) begin
                @(posedge clk);
                #1 chk($sformatf("t4_hold%0d", j), a_if.FABRIC_RESET_N, 1'b0);
            end
            @(negedge clk);
            #10;
            ss = 1'b0;
            ff = 1'b0;
            release_chk($sformatf("t4_rel%0d", j));
        end

        @(negedge clk);
        #10 ext = 1'b0;
        #5;
        chk("t5_pulse_a", a_if.FABRIC_RESET_N, 1'b0);
        chk("t5_pulse_b", b_if.FABRIC_RESET_N, 1'b0);
        #5 ext = 1'b1;
        release_chk("t5");

        @(negedge clk);
        #10 init = 1'b0;
        #10 init = 1'b1;
        repeat (4) @(posedge clk);
        #10 pll = 1'b0;
        #5 chk("t6_pll_b", b_if.FABRIC_RESET_N, 1'b0);
        @(negedge clk);
        #10 pll = 1'b1;
        release_chk("t6");

        for (int c = 0; c < 1200; c++) begin
            int n;
            n = ((c / 40) % 2 == 0) ? 200 : 8;
            @(negedge clk);
            #10;
            if (($urandom % 25) == 0) begin
                ext = 1'b0;
                #10 ext = 1'b1;
            end
            ext  = ($urandom % n) != 0;
            pll  = ($urandom % n) != 0;
            init = ($urandom % n) != 0;
            ss   = ($urandom % (n / 2)) == 0;
            ff   = ($urandom % (n / 2)) == 0;
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
